// File: rtl/masked_share_encoder.sv
// Two-share Boolean masking front end for the masked AND stage: splits a, b, c
// into shares and supplies fresh rN0/rN1 from a reseedable 32-bit Galois LFSR.
module masked_share_encoder #(
  parameter logic [31:0] SEED   = 32'hACE1_2468,
  parameter int unsigned WARMUP = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic [31:0] seed_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_a,
  input  logic        in_b,
  input  logic        in_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        o_a0,
  output logic        o_a1,
  output logic        o_b0,
  output logic        o_b1,
  output logic        o_c0,
  output logic        o_c1,
  output logic        o_rN0,
  output logic        o_rN1
);

  localparam logic [31:0] POLY       = 32'h8020_0003;
  localparam logic [7:0]  WARMUP_CNT = 8'(WARMUP);

  typedef enum logic [0:0] {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  // One advance = eight unrolled Galois steps, so successive share sets never share state bits.
  function automatic logic [31:0] lfsr_advance(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < 8; i++) begin
      if (v[0]) begin
        v = {1'b0, v[31:1]} ^ POLY;
      end else begin
        v = {1'b0, v[31:1]};
      end
    end
    return v;
  endfunction

  // Share packing order: {a0, a1, b0, b1, c0, c1, rN0, rN1}.
  function automatic logic [7:0] encode_shares(input logic [31:0] s, input logic a,
                                               input logic b, input logic c);
    return {s[0], a ^ s[0], s[1], b ^ s[1], s[2], c ^ s[2], s[3], s[4]};
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic        valid_q, valid_d;
  logic [7:0]  shares_q, shares_d;
  logic        in_ready_s;
  logic        accept_s;

  // Next-state logic: seed_load overrides everything, then warm-up, then the handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lfsr_d     = lfsr_q;
    valid_d    = valid_q;
    shares_d   = shares_q;
    in_ready_s = 1'b0;
    accept_s   = 1'b0;
    if (seed_load) begin
      lfsr_d  = (seed_data == 32'h0000_0000) ? SEED : seed_data;
      cnt_d   = 8'd0;
      state_d = ST_WARMUP;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          if (cnt_q >= WARMUP_CNT) begin
            state_d = ST_RUN;
          end else begin
            lfsr_d = lfsr_advance(lfsr_q);
            cnt_d  = cnt_q + 8'd1;
            if ((cnt_q + 8'd1) == WARMUP_CNT) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_WARMUP;
            end
          end
        end
        ST_RUN: begin
          in_ready_s = !valid_q || out_ready;
          accept_s   = in_valid && in_ready_s;
          if (accept_s) begin
            shares_d = encode_shares(lfsr_q, in_a, in_b, in_c);
            valid_d  = 1'b1;
            lfsr_d   = lfsr_advance(lfsr_q);
          end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end
        default: begin
          state_d = ST_WARMUP;
          cnt_d   = 8'd0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_WARMUP;
      cnt_q    <= 8'd0;
      lfsr_q   <= SEED;
      valid_q  <= 1'b0;
      shares_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      valid_q  <= valid_d;
      shares_q <= shares_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = valid_q;
  assign {o_a0, o_a1, o_b0, o_b1, o_c0, o_c1, o_rN0, o_rN1} = shares_q;

endmodule
